// File: rtl/pingpong_dir_ctrl_pkg.sv
// Shared encoding and default widths for the ping-pong direction controller.
package pingpong_dir_ctrl_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_TWIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_t;

endpackage

// File: rtl/pingpong_dir_ctrl_if.sv
// Bus between the sweep controller and whoever owns the counter and limits.
interface pingpong_dir_ctrl_if
   import pingpong_dir_ctrl_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int TWIDTH = DEF_TWIDTH
);
   logic [WIDTH-1:0]  q;
   logic [WIDTH-1:0]  lo_lim;
   logic [WIDTH-1:0]  hi_lim;
   logic              start;
   logic              stop;
   logic              dir;
   logic              busy;
   logic              turn;
   logic [TWIDTH-1:0] turns;
   logic              err;

   modport master (
      output q, lo_lim, hi_lim, start, stop,
      input  dir, busy, turn, turns, err
   );

   modport slave (
      input  q, lo_lim, hi_lim, start, stop,
      output dir, busy, turn, turns, err
   );
endinterface

// File: rtl/pingpong_dir_ctrl_sat_counter.sv
// Saturating event counter; clear wins over increment.
module sat_counter
   import pingpong_dir_ctrl_pkg::*;
#(
   parameter int TWIDTH = DEF_TWIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              clr,
   output logic [TWIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {TWIDTH{1'b1}})) begin
         count <= count + TWIDTH'(1);
      end
   end

endmodule

// File: rtl/pingpong_dir_ctrl.sv
// Sweeps an external up/down counter between latched limits, reversing one
// step early so the counter lands exactly on each limit.
module pingpong_dir_ctrl
   import pingpong_dir_ctrl_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int TWIDTH = DEF_TWIDTH
) (
   input  logic                clk,
   input  logic                rst,
   pingpong_dir_ctrl_if.slave  bus
);

   state_t            state;
   logic [WIDTH-1:0]  lo_q;
   logic [WIDTH-1:0]  hi_q;
   logic              dir_q;
   logic              busy_q;
   logic              turn_q;
   logic              err_q;
   logic [TWIDTH-1:0] turns_cnt;

   logic start_req;
   logic accept;
   logic at_hi;
   logic at_lo;
   logic rev;

   // Start is only honoured from IDLE and is overridden by a concurrent stop.
   assign start_req = bus.start && !bus.stop;
   assign accept    = (state == IDLE) && start_req && (bus.lo_lim < bus.hi_lim);

   // Limits are ordered at latch time, so hi-1 and lo+1 cannot wrap.
   assign at_hi = bus.q >= (hi_q - WIDTH'(1));
   assign at_lo = bus.q <= (lo_q + WIDTH'(1));
   assign rev   = !bus.stop && (((state == UP) && at_hi) || ((state == DOWN) && at_lo));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         lo_q   <= '0;
         hi_q   <= '0;
         dir_q  <= 1'b0;
         busy_q <= 1'b0;
         turn_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         turn_q <= 1'b0;
         case (state)
            IDLE: begin
               dir_q  <= 1'b0;
               busy_q <= 1'b0;
               if (accept) begin
                  lo_q   <= bus.lo_lim;
                  hi_q   <= bus.hi_lim;
                  err_q  <= 1'b0;
                  dir_q  <= 1'b1;
                  busy_q <= 1'b1;
                  state  <= UP;
               end else if (start_req) begin
                  err_q <= 1'b1;
               end
            end
            UP: begin
               if (bus.stop) begin
                  state  <= IDLE;
                  dir_q  <= 1'b0;
                  busy_q <= 1'b0;
               end else if (at_hi) begin
                  state  <= DOWN;
                  dir_q  <= 1'b0;
                  turn_q <= 1'b1;
               end
            end
            DOWN: begin
               if (bus.stop) begin
                  state  <= IDLE;
                  dir_q  <= 1'b0;
                  busy_q <= 1'b0;
               end else if (at_lo) begin
                  state  <= UP;
                  dir_q  <= 1'b1;
                  turn_q <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               dir_q  <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Counts on the same edge that raises turn, so turns and turn stay aligned.
   sat_counter #(.TWIDTH(TWIDTH)) u_turns (
      .clk   (clk),
      .rst   (rst),
      .inc   (rev),
      .clr   (accept),
      .count (turns_cnt)
   );

   assign bus.dir   = dir_q;
   assign bus.busy  = busy_q;
   assign bus.turn  = turn_q;
   assign bus.turns = turns_cnt;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_pingpong_dir_ctrl.sv
// Two controllers (TWIDTH 8 and 2) driving real counters from shared stimulus,
// checked every cycle against a rule-level model plus literal expectations.
module tb_pingpong_dir_ctrl;

   logic       clk;
   logic       rst;
   logic       ld;
   logic [3:0] ldv;
   logic [3:0] lo;
   logic [3:0] hi;
   logic       start;
   logic       stop;
   logic [3:0] cq0;
   logic [3:0] cq1;

   int n_cmp = 0;
   int n_bad = 0;

   pingpong_dir_ctrl_if #(.WIDTH(4), .TWIDTH(8)) b0 ();
   pingpong_dir_ctrl_if #(.WIDTH(4), .TWIDTH(2)) b1 ();

   assign b0.q = cq0;  assign b0.lo_lim = lo; assign b0.hi_lim = hi;
   assign b0.start = start; assign b0.stop = stop;
   assign b1.q = cq1;  assign b1.lo_lim = lo; assign b1.hi_lim = hi;
   assign b1.start = start; assign b1.stop = stop;

   pingpong_dir_ctrl #(.WIDTH(4), .TWIDTH(8)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   pingpong_dir_ctrl #(.WIDTH(4), .TWIDTH(2)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Real up/down counters, one step per clock while the controller is busy.
   always @(posedge clk) begin
      if (ld) begin
         cq0 <= ldv;
         cq1 <= ldv;
      end else begin
         if (b0.busy) cq0 <= b0.dir ? cq0 + 4'd1 : cq0 - 4'd1;
         if (b1.busy) cq1 <= b1.dir ? cq1 + 4'd1 : cq1 - 4'd1;
      end
   end

   // Rule-level model: sweeping flag, heading, latched window, reversal count.
   bit m_run, m_up, m_turn, m_err;
   int m_lo, m_hi, m_n, mq, qo;

   always @(posedge clk) begin
      qo = mq;
      if (ld) mq = int'(ldv);
      else if (rst && m_run) mq = m_up ? (mq + 1) % 16 : (mq + 15) % 16;
      if (!rst) begin
         m_run = 0; m_up = 0; m_turn = 0; m_err = 0; m_n = 0; m_lo = 0; m_hi = 0;
      end else if (!m_run) begin
         m_turn = 0;
         if (start && !stop) begin
            if (lo < hi) begin
               m_lo = int'(lo); m_hi = int'(hi);
               m_run = 1; m_up = 1; m_n = 0; m_err = 0;
            end else m_err = 1;
         end
      end else if (stop) begin
         m_run = 0; m_up = 0; m_turn = 0;
      end else if (m_up ? (qo >= m_hi - 1) : (qo <= m_lo + 1)) begin
         m_up = !m_up; m_turn = 1; m_n++;
      end else m_turn = 0;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input string tg, input logic d, input logic b, input logic t,
                          input logic e, input logic [7:0] tn, input logic [3:0] qq,
                          input int tmax);
      int en;
      en = (m_n > tmax) ? tmax : m_n;
      if (!rst) begin
         chk({tg, ".dir"}, d, 0);  chk({tg, ".busy"}, b, 0); chk({tg, ".turn"}, t, 0);
         chk({tg, ".err"}, e, 0);  chk({tg, ".turns"}, tn, 0);
      end else begin
         chk({tg, ".dir"}, d, m_run && m_up); chk({tg, ".busy"}, b, m_run);
         chk({tg, ".turn"}, t, m_turn);       chk({tg, ".err"}, e, m_err);
         chk({tg, ".turns"}, tn, en);
      end
      chk({tg, ".q"}, qq, mq);
   endtask

   always @(negedge clk) begin
      cmp_dut("m0", b0.dir, b0.busy, b0.turn, b0.err, b0.turns, cq0, 255);
      cmp_dut("m1", b1.dir, b1.busy, b1.turn, b1.err, 8'(b1.turns), cq1, 3);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic go(input logic [3:0] q0, input logic [3:0] l, input logic [3:0] h);
      ld = 1; ldv = q0; lo = l; hi = h; start = 1;
      step(1);
      ld = 0; start = 0;
   endtask

   task automatic halt();
      stop = 1; step(1); stop = 0;
   endtask

   int exp_q[16] = '{3, 4, 5, 6, 5, 4, 3, 2, 3, 4, 5, 6, 5, 4, 3, 2};

   initial begin
      rst = 0; ld = 1; ldv = 4'd2; start = 0; stop = 0; lo = 0; hi = 0;
      step(2);
      chk("rst_dir", b0.dir, 0);   chk("rst_busy", b0.busy, 0);
      chk("rst_turn", b0.turn, 0); chk("rst_turns", b0.turns, 0);
      chk("rst_err", b0.err, 0);
      rst = 1; ld = 0;
      step(1);

      // Full sweep lo=2 hi=6 from q=2
      go(4'd2, 4'd2, 4'd6);
      chk("a_busy", b0.busy, 1); chk("a_dir", b0.dir, 1);
      for (int i = 0; i < 16; i++) begin
         step(1);
         chk("a_qseq", cq0, exp_q[i]);
         chk("a_turnseq", b0.turn, (exp_q[i] == 6 || exp_q[i] == 2));
      end
      chk("a_turns4", b0.turns, 4);
      chk("a_turns_sat2", b1.turns, 3);
      // start while busy ignored, limit inputs wiggle without effect
      lo = 0; hi = 15; start = 1; step(1); start = 0; lo = 9; hi = 3;
      step(8);
      chk("a_frozen_q", cq0, 3);
      chk("a_turns6", b0.turns, 6);
      halt();
      chk("a_stop_busy", b0.busy, 0); chk("a_stop_dir", b0.dir, 0);

      // Invalid limits, then a valid start clears err
      lo = 5; hi = 5; start = 1; step(1); start = 0;
      chk("b_err", b0.err, 1); chk("b_busy", b0.busy, 0); chk("b_dir", b0.dir, 0);
      chk("b_turns_kept", b0.turns, 6);
      lo = 1; hi = 3; start = 1; step(1); start = 0;
      chk("b_err_clr", b0.err, 0); chk("b_busy1", b0.busy, 1);
      chk("b_turns_clr", b0.turns, 0);
      step(6);
      halt();

      // Width-1 window: reverses every cycle
      go(4'd7, 4'd7, 4'd8);
      for (int i = 1; i <= 6; i++) begin
         step(1);
         chk("c_turn", b0.turn, 1);
         chk("c_q", cq0, (i % 2) ? 8 : 7);
      end
      halt();

      // Saturation of the narrow counter
      go(4'd0, 4'd0, 4'd1);
      step(10);
      chk("d_turns_sat", b1.turns, 3);
      chk("d_turns10", b0.turns, 10);
      halt();

      // Stop in the same cycle as a reversal condition
      go(4'd2, 4'd2, 4'd6);
      step(3);
      chk("e_q5", cq0, 5);
      halt();
      chk("e_turn", b0.turn, 0); chk("e_dir", b0.dir, 0); chk("e_busy", b0.busy, 0);

      // q above window at start turns immediately
      go(4'd9, 4'd2, 4'd6);
      step(1);
      chk("f_turn", b0.turn, 1); chk("f_dir", b0.dir, 0);
      step(12);
      halt();

      // Asynchronous reset mid-sweep
      go(4'd2, 4'd2, 4'd6);
      step(2);
      #1 rst = 0;
      #1;
      chk("g_dir", b0.dir, 0);     chk("g_busy", b0.busy, 0);
      chk("g_turn", b0.turn, 0);   chk("g_turns", b0.turns, 0);
      chk("g_err", b0.err, 0);     chk("g_busy1", b1.busy, 0);
      step(1);
      rst = 1;
      step(1);
      chk("g_idle", b0.busy, 0);
      lo = 1; hi = 4; start = 1; step(1); start = 0;
      chk("g_restart", b0.busy, 1);
      step(4);
      halt();
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
